// File: rtl/rggen_host_if_axi4lite.sv
`timescale 1ns/1ps
// AXI4-Lite slave feeding the rggen local command bus, one transaction outstanding.
// Command issues the cycle after final AW/W/AR capture; B/R follow i_response_ready by one cycle.
module rggen_host_if_axi4lite #(
  parameter int DATA_WIDTH          = 32,
  parameter int HOST_ADDRESS_WIDTH  = 16,
  parameter int LOCAL_ADDRESS_WIDTH = 8,
  parameter bit WRITE_FIRST         = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_awvalid,
  output logic                           o_awready,
  input  logic [HOST_ADDRESS_WIDTH-1:0]  i_awaddr,
  input  logic [2:0]                     i_awprot,
  input  logic                           i_wvalid,
  output logic                           o_wready,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  output logic                           o_bvalid,
  input  logic                           i_bready,
  output logic [1:0]                     o_bresp,
  input  logic                           i_arvalid,
  output logic                           o_arready,
  input  logic [HOST_ADDRESS_WIDTH-1:0]  i_araddr,
  input  logic [2:0]                     i_arprot,
  output logic                           o_rvalid,
  input  logic                           i_rready,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [1:0]                     o_rresp,
  output logic                           o_command_valid,
  output logic                           o_write,
  output logic                           o_read,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH/8-1:0]        o_strobe,
  output logic [DATA_WIDTH-1:0]          o_write_data,
  output logic [DATA_WIDTH-1:0]          o_write_mask,
  input  logic                           i_response_ready,
  input  logic [DATA_WIDTH-1:0]          i_read_data,
  input  logic [1:0]                     i_status
);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WRITE, READ, B_RESP, R_RESP} state_e;

  state_e                         state_q, state_d;
  logic                           aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                           awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                           cmd_valid_q, cmd_valid_d, write_q, write_d, read_q, read_d;
  logic [LOCAL_ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [SW-1:0]                  strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d, mask_q, mask_d, rdata_q, rdata_d;
  logic                           bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                     bresp_q, bresp_d, rresp_q, rresp_d;
  logic                           aw_hs, w_hs, ar_hs, aw_pend, w_pend, ar_pend;
  logic                           rd_sel, slots_empty, idle_next;
  logic [DATA_WIDTH-1:0]          wstrb_mask;
  logic                           unused_inputs;

  assign unused_inputs = ^{i_awprot, i_arprot, i_awaddr, i_araddr};

  assign aw_hs   = i_awvalid & awready_q;
  assign w_hs    = i_wvalid & wready_q;
  assign ar_hs   = i_arvalid & arready_q;
  assign aw_pend = i_awvalid & ~aw_hs;
  assign w_pend  = i_wvalid & ~w_hs;
  assign ar_pend = i_arvalid & ~ar_hs;

  always_comb begin
    wstrb_mask = '0;
    for (int i = 0; i < SW; i++) wstrb_mask[8*i +: 8] = {8{i_wstrb[i]}};
  end

  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    cmd_valid_d = cmd_valid_q;
    write_d     = write_q;
    read_d      = read_q;
    address_d   = address_q;
    strobe_d    = strobe_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          address_d = i_awaddr[LOCAL_ADDRESS_WIDTH-1:0];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = i_wdata;
          strobe_d = i_wstrb;
          mask_d   = wstrb_mask;
        end
        if (ar_hs) begin
          address_d = i_araddr[LOCAL_ADDRESS_WIDTH-1:0];
          strobe_d  = '1;
          mask_d    = '1;
        end
        if (aw_held_d && w_held_d) begin
          state_d     = WRITE;
          cmd_valid_d = 1'b1;
          write_d     = 1'b1;
          aw_held_d   = 1'b0;
          w_held_d    = 1'b0;
        end else if (ar_hs) begin
          state_d     = READ;
          cmd_valid_d = 1'b1;
          read_d      = 1'b1;
        end
      end
      WRITE: if (i_response_ready) begin
        state_d     = B_RESP;
        cmd_valid_d = 1'b0;
        write_d     = 1'b0;
        bvalid_d    = 1'b1;
        bresp_d     = i_status;
      end
      READ: if (i_response_ready) begin
        state_d     = R_RESP;
        cmd_valid_d = 1'b0;
        read_d      = 1'b0;
        rvalid_d    = 1'b1;
        rresp_d     = i_status;
        rdata_d     = i_read_data;
      end
      B_RESP: if (i_bready) begin
        state_d  = IDLE;
        bvalid_d = 1'b0;
      end
      R_RESP: if (i_rready) begin
        state_d  = IDLE;
        rvalid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Readies are registered, so write and read readies are never high together:
    // otherwise a fresh AW+W+AR arrival would complete all three handshakes at once.
    idle_next   = (state_d == IDLE);
    slots_empty = ~aw_held_d & ~w_held_d;
    if (WRITE_FIRST) rd_sel = ar_pend & ~aw_pend & ~w_pend;
    else             rd_sel = ar_pend | ~(aw_pend | w_pend);
    arready_d = idle_next & slots_empty & rd_sel;
    awready_d = idle_next & ~aw_held_d & ~(slots_empty & rd_sel);
    wready_d  = idle_next & ~w_held_d & ~(slots_empty & rd_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      address_q   <= '0;
      strobe_q    <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      cmd_valid_q <= cmd_valid_d;
      write_q     <= write_d;
      read_q      <= read_d;
      address_q   <= address_d;
      strobe_q    <= strobe_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_awready       = awready_q;
  assign o_wready        = wready_q;
  assign o_arready       = arready_q;
  assign o_bvalid        = bvalid_q;
  assign o_bresp         = bresp_q;
  assign o_rvalid        = rvalid_q;
  assign o_rdata         = rdata_q;
  assign o_rresp         = rresp_q;
  assign o_command_valid = cmd_valid_q;
  assign o_write         = write_q;
  assign o_read          = read_q;
  assign o_address       = address_q;
  assign o_strobe        = strobe_q;
  assign o_write_data    = wdata_q;
  assign o_write_mask    = mask_q;
endmodule

// File: tb/tb_rggen_host_if_axi4lite.sv
`timescale 1ns/1ps
// Bench for rggen_host_if_axi4lite: directed AXI scenarios on both collision priorities,
// then random traffic checked against a word-array model of the register space.
module tb_rggen_host_if_axi4lite;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        awvalid, wvalid, arvalid, bready, rready, resp_rdy;
  logic [15:0] awaddr, araddr;
  logic [31:0] wdata, read_data;
  logic [3:0]  wstrb;
  logic [1:0]  status;
  logic [2:0]  prot;
  logic        awready, wready, arready, bvalid, rvalid, cmd_valid, cmd_write, cmd_read;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, cmd_wdata, cmd_wmask;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_strobe;

  logic        z_awvalid, z_wvalid, z_arvalid, z_bready, z_rready, z_resp_rdy;
  logic        z_awready, z_wready, z_arready, z_bvalid, z_rvalid, z_cmd_valid, z_cmd_write, z_cmd_read;
  logic [1:0]  z_bresp, z_rresp;
  logic [31:0] z_rdata, z_cmd_wdata, z_cmd_wmask;
  logic [7:0]  z_cmd_addr;
  logic [3:0]  z_cmd_strobe;

  rggen_host_if_axi4lite #(.WRITE_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr), .i_awprot(prot),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr), .i_arprot(prot),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
    .o_command_valid(cmd_valid), .o_write(cmd_write), .o_read(cmd_read), .o_address(cmd_addr),
    .o_strobe(cmd_strobe), .o_write_data(cmd_wdata), .o_write_mask(cmd_wmask),
    .i_response_ready(resp_rdy), .i_read_data(read_data), .i_status(status)
  );

  rggen_host_if_axi4lite #(.WRITE_FIRST(1'b0)) dut_rf (
    .clk(clk), .rst_n(rst_n),
    .i_awvalid(z_awvalid), .o_awready(z_awready), .i_awaddr(awaddr), .i_awprot(prot),
    .i_wvalid(z_wvalid), .o_wready(z_wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(z_bvalid), .i_bready(z_bready), .o_bresp(z_bresp),
    .i_arvalid(z_arvalid), .o_arready(z_arready), .i_araddr(araddr), .i_arprot(prot),
    .o_rvalid(z_rvalid), .i_rready(z_rready), .o_rdata(z_rdata), .o_rresp(z_rresp),
    .o_command_valid(z_cmd_valid), .o_write(z_cmd_write), .o_read(z_cmd_read), .o_address(z_cmd_addr),
    .o_strobe(z_cmd_strobe), .o_write_data(z_cmd_wdata), .o_write_mask(z_cmd_wmask),
    .i_response_ready(z_resp_rdy), .i_read_data(read_data), .i_status(status)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int n_cmd = 0;
  int n_rsp = 0;
  logic cmd_prev = 1'b0;
  logic [31:0] ref_mem [64];
  logic [31:0] regblk [64];

  // Observes the local bus and AXI responses so lost or duplicated transfers show up as count errors.
  always @(posedge clk) begin
    cmd_prev <= cmd_valid;
    if (cmd_valid && !cmd_prev) n_cmd <= n_cmd + 1;
    if ((bvalid && bready) || (rvalid && rready)) n_rsp <= n_rsp + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expand(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic drive_aw(input logic [15:0] a, input int dly);
    bit ok;
    ok = 1'b0;
    repeat (dly) tick();
    awvalid = 1'b1;
    awaddr  = a;
    for (int i = 0; i < 40; i++) begin
      if (awready) begin ok = 1'b1; tick(); break; end
      tick();
    end
    awvalid = 1'b0;
    check("aw_accept", 64'(ok), 64'd1);
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit ok;
    ok = 1'b0;
    repeat (dly) tick();
    wvalid = 1'b1;
    wdata  = d;
    wstrb  = s;
    for (int i = 0; i < 40; i++) begin
      if (wready) begin ok = 1'b1; tick(); break; end
      tick();
    end
    wvalid = 1'b0;
    check("w_accept", 64'(ok), 64'd1);
  endtask

  task automatic drive_ar(input logic [15:0] a, input int dly);
    bit ok;
    ok = 1'b0;
    repeat (dly) tick();
    arvalid = 1'b1;
    araddr  = a;
    for (int i = 0; i < 40; i++) begin
      if (arready) begin ok = 1'b1; tick(); break; end
      tick();
    end
    arvalid = 1'b0;
    check("ar_accept", 64'(ok), 64'd1);
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] st);
    resp_rdy  = 1'b1;
    read_data = d;
    status    = st;
    tick();
    resp_rdy  = 1'b0;
  endtask

  // Full transaction: AXI stimulus, register-block responder on the local bus, response check.
  task automatic do_txn(input bit is_wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx, j, dly_a, dly_w;
    bit ok;
    logic [1:0]  exp_st, st;
    logic [31:0] exp_rd, rd_val;
    idx    = int'(a[7:2]);
    exp_st = (a[7:6] == 2'b11) ? 2'b10 : 2'b00;
    exp_rd = ref_mem[idx];
    if (is_wr && exp_st == 2'b00)
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    dly_a = $urandom_range(0, 3);
    dly_w = $urandom_range(0, 3);
    if (is_wr) fork
      drive_aw(a, dly_a);
      drive_w(d, s, dly_w);
    join
    else drive_ar(a, dly_a);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_valid) begin ok = 1'b1; break; end
      tick();
    end
    check("txn_cmd_seen", 64'(ok), 64'd1);
    check("txn_kind", 64'({cmd_write, cmd_read}), 64'(is_wr ? 2'b10 : 2'b01));
    check("txn_addr", 64'(cmd_addr), 64'(a[7:0]));
    if (is_wr) begin
      check("txn_wdata", 64'(cmd_wdata), 64'(d));
      check("txn_wmask", 64'(cmd_wmask), 64'(expand(s)));
    end else check("txn_rstrobe", 64'(cmd_strobe), 64'hF);
    repeat ($urandom_range(0, 3)) tick();
    j      = int'(cmd_addr[7:2]);
    st     = (cmd_addr[7:6] == 2'b11) ? 2'b10 : 2'b00;
    rd_val = regblk[j];
    if (cmd_write && st == 2'b00) regblk[j] = (regblk[j] & ~cmd_wmask) | (cmd_wdata & cmd_wmask);
    respond(rd_val, st);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (is_wr) bready = 1'($urandom_range(0, 1));
      else       rready = 1'($urandom_range(0, 1));
      if (is_wr ? (bvalid && bready) : (rvalid && rready)) begin
        if (is_wr) check("txn_bresp", 64'(bresp), 64'(exp_st));
        else begin
          check("txn_rresp", 64'(rresp), 64'(exp_st));
          check("txn_rdata", 64'(rdata), 64'(exp_rd));
        end
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bready = 1'b0;
    rready = 1'b0;
    check("txn_resp_seen", 64'(ok), 64'd1);
  endtask

  initial begin
    bit ok, stable;
    int snap_cmd, snap_rsp;
    logic [15:0] a;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0; resp_rdy = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; read_data = '0; status = '0; prot = '0;
    z_awvalid = 0; z_wvalid = 0; z_arvalid = 0; z_bready = 0; z_rready = 0; z_resp_rdy = 0;
    for (int i = 0; i < 64; i++) begin ref_mem[i] = '0; regblk[i] = '0; end

    // Reset values and first ready assertion
    #2;
    check("rst_ctl", 64'({awready, wready, arready, bvalid, rvalid, cmd_valid, cmd_write, cmd_read, bresp, rresp}), 64'd0);
    check("rst_dat", 64'({rdata, cmd_wmask}), 64'd0);
    check("rst_dat2", 64'({cmd_addr, cmd_strobe, cmd_wdata}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rdy_after_rst", 64'({awready, wready, arready}), 64'b110);
    check("z_rdy_after_rst", 64'({z_awready, z_wready, z_arready}), 64'b001);

    // 1: AW+W same cycle
    awvalid = 1; awaddr = 16'h0004; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    check("t1_cmd", 64'({cmd_valid, cmd_write, cmd_read}), 64'b110);
    check("t1_addr", 64'(cmd_addr), 64'h04);
    check("t1_wdata", 64'(cmd_wdata), 64'hDEADBEEF);
    check("t1_wmask", 64'(cmd_wmask), 64'hFFFFFFFF);
    check("t1_rdy_busy", 64'({awready, wready, arready}), 64'b000);
    repeat (2) tick();
    check("t1_hold", 64'({cmd_valid, cmd_write, cmd_addr, cmd_wdata}), 64'({2'b11, 8'h04, 32'hDEADBEEF}));
    respond(32'h0, 2'b00);
    check("t1_bvalid", 64'({bvalid, bresp, cmd_valid, rvalid}), 64'b1_00_0_0);
    tick();
    check("t1_bhold", 64'(bvalid), 64'd1);
    bready = 1; tick(); bready = 0;
    check("t1_after_b", 64'({bvalid, awready, wready}), 64'b011);

    // 2: W three cycles ahead of AW, upper address bits dropped
    snap_cmd = n_cmd;
    wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'h5;
    tick();
    wvalid = 0;
    stable = 1'b1;
    repeat (3) begin
      if (wready || cmd_valid || !awready) stable = 1'b0;
      tick();
    end
    check("t2_w_held", 64'(stable), 64'd1);
    awvalid = 1; awaddr = 16'hAB10;
    tick();
    awvalid = 0;
    check("t2_cmd", 64'({cmd_valid, cmd_write, cmd_addr, cmd_strobe}), 64'({2'b11, 8'h10, 4'h5}));
    check("t2_wmask", 64'(cmd_wmask), 64'h00FF00FF);
    check("t2_wdata", 64'(cmd_wdata), 64'hCAFEF00D);
    respond(32'h0, 2'b00);
    bready = 1; tick(); bready = 0;
    check("t2_one_cmd", 64'(n_cmd - snap_cmd), 64'd1);

    // 3: read with SLVERR and R backpressure
    drive_ar(16'h0008, 0);
    check("t3_cmd", 64'({cmd_valid, cmd_write, cmd_read, cmd_addr, cmd_strobe}), 64'({3'b101, 8'h08, 4'hF}));
    respond(32'h12345678, 2'b10);
    check("t3_r", 64'({rvalid, rresp, rdata}), 64'({1'b1, 2'b10, 32'h12345678}));
    read_data = 32'h0; status = 2'b00;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (!rvalid || rdata !== 32'h12345678 || rresp !== 2'b10) stable = 1'b0;
    end
    check("t3_r_hold", 64'(stable), 64'd1);
    rready = 1; tick(); rready = 0;
    check("t3_after_r", 64'(rvalid), 64'd0);

    // 4a: collision, write wins
    awvalid = 1; awaddr = 16'h0020; wvalid = 1; wdata = 32'h11112222; wstrb = 4'hF;
    arvalid = 1; araddr = 16'h0024;
    tick();
    awvalid = 0; wvalid = 0;
    check("t4_write_first", 64'({cmd_valid, cmd_write, cmd_addr}), 64'({2'b11, 8'h20}));
    check("t4_ar_blocked", 64'(arready), 64'd0);
    respond(32'h0, 2'b00);
    check("t4_b", 64'({bvalid, arready}), 64'b10);
    bready = 1; tick(); bready = 0;
    check("t4_no_cmd_yet", 64'(cmd_valid), 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (arready) begin ok = 1'b1; tick(); break; end
      tick();
    end
    arvalid = 0;
    check("t4_ar_taken", 64'(ok), 64'd1);
    check("t4_read_second", 64'({cmd_valid, cmd_read, cmd_addr}), 64'({2'b11, 8'h24}));
    respond(32'h0000A5A5, 2'b00);
    rready = 1; tick(); rready = 0;

    // 4b: collision, read wins
    z_awvalid = 1; awaddr = 16'h0030; z_wvalid = 1; wdata = 32'h55667788; wstrb = 4'h8;
    z_arvalid = 1; araddr = 16'h0034;
    tick();
    z_arvalid = 0;
    check("t4z_read_first", 64'({z_cmd_valid, z_cmd_write, z_cmd_read, z_cmd_addr, z_cmd_strobe}), 64'({3'b101, 8'h34, 4'hF}));
    check("t4z_w_blocked", 64'({z_awready, z_wready}), 64'b00);
    z_resp_rdy = 1; read_data = 32'h0BADF00D; status = 2'b01; tick(); z_resp_rdy = 0;
    check("t4z_r", 64'({z_rvalid, z_rresp, z_rdata}), 64'({1'b1, 2'b01, 32'h0BADF00D}));
    z_rready = 1; tick(); z_rready = 0;
    check("t4z_after_r", 64'({z_cmd_valid, z_awready, z_wready, z_arready}), 64'b0110);
    tick();
    z_awvalid = 0; z_wvalid = 0;
    check("t4z_write_second", 64'({z_cmd_valid, z_cmd_write, z_cmd_read, z_cmd_addr}), 64'({3'b110, 8'h30}));
    check("t4z_wdata", 64'({z_cmd_wdata, z_cmd_wmask}), 64'({32'h55667788, 32'hFF000000}));
    z_resp_rdy = 1; status = 2'b11; tick(); z_resp_rdy = 0;
    check("t4z_b", 64'({z_bvalid, z_bresp}), 64'b111);
    z_bready = 1; tick(); z_bready = 0;
    check("t4z_after_b", 64'(z_bvalid), 64'd0);
    status = 2'b00;

    // 5: reset in the middle of a command
    awvalid = 1; awaddr = 16'h0040; wvalid = 1; wdata = 32'h0F0F0F0F; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    check("t5_cmd", 64'(cmd_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", 64'({awready, wready, arready, bvalid, rvalid, cmd_valid, cmd_write, cmd_read, bresp, rresp}), 64'd0);
    check("t5_rst_dat", 64'({cmd_addr, cmd_strobe, cmd_wdata}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    respond(32'h0, 2'b00);
    stable = 1'b1;
    repeat (4) begin
      if (bvalid || cmd_valid) stable = 1'b0;
      tick();
    end
    check("t5_no_b", 64'(stable), 64'd1);
    do_txn(1'b1, 16'h0044, 32'hA1B2C3D4, 4'hF);
    do_txn(1'b0, 16'h0044, 32'h0, 4'h0);

    // 6: random traffic against the reference model
    snap_cmd = n_cmd;
    snap_rsp = n_rsp;
    for (int t = 0; t < 100; t++) begin
      a = 16'($urandom);
      a[5:4] = 2'b00;
      a[1:0] = 2'b00;
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end
    tick();
    check("t6_cmd_count", 64'(n_cmd - snap_cmd), 64'd100);
    check("t6_rsp_count", 64'(n_rsp - snap_rsp), 64'd100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
